// File: rtl/tms9900_bus_initiator_pkg.sv
// Shared definitions for the TMS9900-style bus initiator.
//   bus_state_e    : initiator FSM states (IDLE encodes as 0)
//   bus_req_t      : word request latched at acceptance
//   addr_scramble(): parallel image loaded into the LV165 pair; it matches
//                    the bit order that memory_interface decodes from
//                    adrin1/adrin2.
package tms9900_bus_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,   // no request
    ST_WAIT = 3'd1,   // request accepted, waiting for the next phi3 period
    ST_ADDR = 3'd2,   // address period, memen low
    ST_DHI  = 3'd3,   // MSB data periods
    ST_DLO  = 3'd4,   // LSB data periods
    ST_END  = 3'd5    // memen released, ack on last clk
  } bus_state_e;

  typedef struct packed {
    logic        write;
    logic [15:1] addr;   // word address; byte select comes from a15
    logic [15:0] wdata;
  } bus_req_t;

  localparam bus_req_t REQ_RST = '0;

  // Register bit layout: [15:8] is the high LV165 (adrin1), [7:0] the low
  // one (adrin2). Bit 15/7 is presented first.
  function automatic logic [15:0] addr_scramble(input logic [15:1] addr,
                                                input logic        a15);
    logic [15:0] sr;
    sr     = '0;
    sr[11] = addr[15];
    sr[12] = addr[14];
    sr[14] = addr[13];
    sr[2]  = addr[12];
    sr[6]  = addr[11];
    sr[7]  = addr[10];
    sr[13] = addr[9];
    sr[9]  = addr[8];
    sr[8]  = addr[7];
    sr[15] = addr[6];
    sr[0]  = addr[5];
    sr[1]  = addr[4];
    sr[5]  = addr[3];
    sr[3]  = addr[2];
    sr[4]  = addr[1];
    sr[10] = a15;
    return sr;
  endfunction

endpackage

// File: rtl/tms9900_bus_initiator_lv165_pair_model.sv
// Model of two cascaded-in-parallel LV165 shift registers.
//   clk, reset : system clock, synchronous active-high reset
//   i_shld     : parallel load, active low, level sensitive (load wins over shift)
//   i_serclk   : shift clock, rising edge detected in the clk domain
//   i_par      : parallel image, [15:8] high register, [7:0] low register
//   o_adrin1   : serial output of the high register (bit 7 of byte 1)
//   o_adrin2   : serial output of the low register (bit 7 of byte 0)
module lv165_pair_model #(
  parameter int NUM_LANES = 2,
  parameter int VEC_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_shld,
  input  logic                         i_serclk,
  input  logic [NUM_LANES*VEC_W-1:0]   i_par,
  output logic                         o_adrin1,
  output logic                         o_adrin2
);

  logic                 serclk_q;
  logic                 serclk_rise;
  logic [NUM_LANES-1:0] lane_msb;

  assign serclk_rise = i_serclk & ~serclk_q;

  always_ff @(posedge clk) begin
    if (reset) serclk_q <= 1'b0;
    else       serclk_q <= i_serclk;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] sr;

    always_ff @(posedge clk) begin
      if (reset)            sr <= '0;
      else if (!i_shld)     sr <= i_par[l*VEC_W +: VEC_W];
      else if (serclk_rise) sr <= {sr[VEC_W-2:0], 1'b0};
    end

    assign lane_msb[l] = sr[VEC_W-1];
  end

  assign o_adrin1 = lane_msb[NUM_LANES-1];
  assign o_adrin2 = lane_msb[0];

endmodule

// File: rtl/tms9900_bus_initiator.sv
// TI-99/4A multiplexed bus initiator: one 16-bit word request becomes an
// address period, an MSB byte cycle (a15=0), an LSB byte cycle (a15=1) and
// an end period, all aligned to a free-running phi3 phase counter.
//   clk, reset        : clock, synchronous active-high reset
//   i_req/i_write     : word request (taken only while o_busy=0), direction
//   i_addr/i_wdata    : word address (bit 0 ignored), write word
//   o_busy/o_ack      : request in flight / 1-clk completion pulse
//   o_rdata           : read word, updated only at the read's ack
//   o_phi3            : phase clock, low on count 0
//   o_memen/o_dbin    : memory enable (low active), read direction
//   o_we/o_a15        : write strobe (low active), byte select
//   o_data_bus/oe     : write byte and its drive enable
//   i_data_bus        : read byte from responder
//   i_ready           : 0 extends the current data byte by one period
//   i_shld/i_serclk   : LV165 load (low) and shift clock
//   o_adrin1/o_adrin2 : serial address bits, high/low register
//   o_state           : FSM state for debug
module tms9900_bus_initiator
  import tms9900_bus_initiator_pkg::*;
#(
  parameter int PHI3_PERIOD = 4,   // >= 4 so the write strobe has room inside a period
  parameter int MUX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_busy,
  output logic        o_ack,
  output logic [15:0] o_rdata,
  output logic        o_phi3,
  output logic        o_memen,
  output logic        o_dbin,
  output logic        o_we,
  output logic        o_a15,
  output logic [7:0]  o_data_bus,
  output logic        o_data_oe,
  input  logic [7:0]  i_data_bus,
  input  logic        i_ready,
  input  logic        i_shld,
  input  logic        i_serclk,
  output logic        o_adrin1,
  output logic        o_adrin2,
  output logic [2:0]  o_state
);

  localparam int CW = $clog2(PHI3_PERIOD);
  localparam int RW = $clog2(MUX_WAIT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(PHI3_PERIOD - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(PHI3_PERIOD - 2);
  localparam logic [RW-1:0] REM_LOAD = RW'(MUX_WAIT);

  bus_state_e    state_q, state_d;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rem_q, rem_d;     // data periods still owed after this one
  bus_req_t      req_q;
  logic [7:0]    rbuf_hi, rbuf_lo;
  logic [15:0]   rdata_q;
  logic          phi3_q;
  logic          wrap, last_per, accept, byte_done;
  logic          unused_addr0;

  assign unused_addr0 = i_addr[0];
  assign wrap         = (cnt == CNT_LAST);
  assign last_per     = (rem_q == '0);
  // A byte ends only at a boundary with ready high and no periods owed.
  assign byte_done    = wrap && i_ready && last_per;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    accept     = 1'b0;
    o_memen    = 1'b1;
    o_dbin     = 1'b0;
    o_we       = 1'b1;
    o_a15      = 1'b0;
    o_data_oe  = 1'b0;
    o_data_bus = '0;
    o_ack      = 1'b0;
    o_busy     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_req) begin
          accept  = 1'b1;
          // Accepted on the wrap clk: the address period starts right away.
          state_d = wrap ? ST_ADDR : ST_WAIT;
        end
      end
      ST_WAIT: if (wrap) state_d = ST_ADDR;
      ST_ADDR: begin
        o_memen = 1'b0;
        o_dbin  = ~req_q.write;
        if (wrap) begin
          state_d = ST_DHI;
          rem_d   = REM_LOAD;
        end
      end
      ST_DHI, ST_DLO: begin
        o_memen    = 1'b0;
        o_dbin     = ~req_q.write;
        o_a15      = (state_q == ST_DLO);
        o_data_oe  = req_q.write;
        if (req_q.write)
          o_data_bus = (state_q == ST_DLO) ? req_q.wdata[7:0] : req_q.wdata[15:8];
        // Strobe sits strictly inside the period so memen/dbin/a15, which only
        // move at count 0, are stable around it.
        if (req_q.write && last_per && cnt != '0 && cnt != CNT_LAST)
          o_we = 1'b0;
        if (wrap && i_ready) begin
          if (last_per) begin
            state_d = (state_q == ST_DHI) ? ST_DLO : ST_END;
            rem_d   = REM_LOAD;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      ST_END: begin
        if (wrap) begin
          o_ack  = 1'b1;
          o_busy = 1'b0;
          // Back-to-back: a request seen on the ack clk skips IDLE entirely.
          if (i_req) begin
            accept  = 1'b1;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        o_busy  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt     <= '0;
      phi3_q  <= 1'b0;
      rem_q   <= '0;
      req_q   <= REQ_RST;
      rbuf_hi <= '0;
      rbuf_lo <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= wrap ? '0 : cnt + 1'b1;
      phi3_q  <= ~wrap;                 // next count is nonzero unless wrapping
      rem_q   <= rem_d;
      if (accept)
        req_q <= '{write: i_write, addr: i_addr[15:1], wdata: i_wdata};
      if (!req_q.write && byte_done) begin
        if (state_q == ST_DHI) rbuf_hi <= i_data_bus;
        if (state_q == ST_DLO) rbuf_lo <= i_data_bus;
      end
      // Publish on the clk before ack so o_rdata is valid with the pulse.
      if (state_q == ST_END && cnt == CNT_PRE && !req_q.write)
        rdata_q <= {rbuf_hi, rbuf_lo};
    end
  end

  assign o_phi3  = phi3_q;
  assign o_rdata = rdata_q;
  assign o_state = state_q;

  lv165_pair_model #(.NUM_LANES(2), .VEC_W(8)) u_lv165 (
    .clk      (clk),
    .reset    (reset),
    .i_shld   (i_shld),
    .i_serclk (i_serclk),
    .i_par    (addr_scramble(req_q.addr, o_a15)),
    .o_adrin1 (o_adrin1),
    .o_adrin2 (o_adrin2)
  );

endmodule

// File: tb/tb_tms9900_bus_initiator.sv
module tb_tms9900_bus_initiator;
  localparam int P  = 4;
  localparam int MW = 4;
  // Position in the LV165 image of each address bit; entry 0 is the a15 slot.
  localparam int SR_POS [0:15] = '{10, 4, 3, 5, 1, 0, 15, 8, 9, 13, 7, 6, 2, 14, 12, 11};

  logic        clk = 1'b0, reset = 1'b1;
  logic        i_req = 0, i_write = 0, i_ready = 1, i_shld = 1, i_serclk = 0;
  logic [15:0] i_addr = 0, i_wdata = 0;
  logic [7:0]  i_data_bus = 0;
  logic        o_busy, o_ack, o_phi3, o_memen, o_dbin, o_we, o_a15, o_data_oe;
  logic        o_adrin1, o_adrin2;
  logic [15:0] o_rdata;
  logic [7:0]  o_data_bus;
  logic [2:0]  o_state;

  int          n_cmp = 0, n_err = 0, ph = 0;
  logic [15:0] exp_rdata = 0;

  always #5 clk = ~clk;

  tms9900_bus_initiator #(.PHI3_PERIOD(P), .MUX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_ack(o_ack), .o_rdata(o_rdata),
    .o_phi3(o_phi3), .o_memen(o_memen), .o_dbin(o_dbin), .o_we(o_we), .o_a15(o_a15),
    .o_data_bus(o_data_bus), .o_data_oe(o_data_oe), .i_data_bus(i_data_bus),
    .i_ready(i_ready), .i_shld(i_shld), .i_serclk(i_serclk), .o_adrin1(o_adrin1),
    .o_adrin2(o_adrin2), .o_state(o_state)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clk; ph tracks the phase count the design should hold afterwards.
  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    ph = r ? 0 : (ph + 1) % P;
    #1;
  endtask

  function automatic logic [15:0] scr(input logic [15:0] a, input logic a15);
    logic [15:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) s[SR_POS[i]] = a[i];
    s[SR_POS[0]] = a15;
    return s;
  endfunction

  // One word transaction; nh/nl = number of ready-low boundaries in each byte.
  task automatic do_txn(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int nh, input int nl);
    int k, lat, guard, t_dlo, t_end, t_ack;
    int a15_rise, memen_rise, lo_cnt, oe_cnt, we_cnt, we_first, ack_cnt, ack_r;
    int bus_err, stab_err, phi_err;
    logic pm, pd, pa;
    guard = 0;
    while (o_busy && guard < 200) begin tick(); guard++; end
    chk("idle_before_req", o_busy, 0);
    i_req = 1; i_write = wr; i_addr = a; i_wdata = wd;
    k = ph;
    tick();
    i_req = 0; i_write = 1'($urandom); i_addr = 16'($urandom); i_wdata = 16'($urandom);
    chk("busy_after_accept", o_busy, 1);
    lat = 1;
    while (o_memen && lat <= P + 1) begin tick(); lat++; end
    chk("start_latency", lat, P - k);
    chk("addr_period", {o_dbin, o_a15}, {~wr, 1'b0});
    t_dlo = P * (2 + MW + nh);
    t_end = t_dlo + P * (1 + MW + nl);
    t_ack = t_end + P - 1;
    a15_rise = -1; memen_rise = -1; we_first = -1; ack_r = -1;
    lo_cnt = 0; oe_cnt = 0; we_cnt = 0; ack_cnt = 0; bus_err = 0; stab_err = 0; phi_err = 0;
    pm = o_memen; pd = o_dbin; pa = o_a15;
    for (int r = 0; r <= t_ack + 1; r++) begin
      if (o_phi3 !== (r % P != 0)) phi_err++;
      if (o_a15 && a15_rise < 0) a15_rise = r;
      if (o_memen && memen_rise < 0) memen_rise = r;
      if (!o_memen) lo_cnt++;
      if (o_data_oe) oe_cnt++;
      if (!o_we) begin
        we_cnt++;
        if (we_first < 0) we_first = r;
        if (o_data_bus !== (o_a15 ? wd[7:0] : wd[15:8]) || !o_data_oe) bus_err++;
        if (o_memen !== pm || o_dbin !== pd || o_a15 !== pa) stab_err++;
      end
      if (o_ack) begin
        ack_cnt++; ack_r = r;
        chk("rdata_at_ack", o_rdata, wr ? exp_rdata : rd);
      end
      pm = o_memen; pd = o_dbin; pa = o_a15;
      // Responder inputs for the edge that closes cycle r.
      i_ready = 1;
      if (r % P == P - 1) begin
        if (r >= P && r < t_dlo && (r - P) / P < nh) i_ready = 0;
        if (r >= t_dlo && r < t_end && (r - t_dlo) / P < nl) i_ready = 0;
      end
      i_data_bus = (r == t_dlo - 1) ? rd[15:8] : (r == t_end - 1) ? rd[7:0] : 8'($urandom);
      if (r <= t_ack) tick();
    end
    i_ready = 1;
    chk("a15_rise", a15_rise, t_dlo);
    chk("memen_rise", memen_rise, t_end);
    chk("memen_low_clks", lo_cnt, t_end);
    chk("ack_count", ack_cnt, 1);
    chk("ack_time", ack_r, t_ack);
    chk("idle_after_ack", {o_busy, o_memen, o_data_oe}, 3'b010);
    chk("phi3_shape", phi_err, 0);
    chk("we_low_clks", we_cnt, wr ? 2 * (P - 2) : 0);
    chk("oe_clks", oe_cnt, wr ? t_end - P : 0);
    if (wr) begin
      chk("we_first", we_first, P * (1 + MW + nh) + 1);
      chk("write_bus", bus_err, 0);
      chk("stable_under_we", stab_err, 0);
    end else begin
      exp_rdata = rd;
    end
  endtask

  task automatic ser_check(input logic [15:0] a);
    logic [15:0] e;
    logic [7:0]  oh, ol;
    e = scr(a, 1'b0);
    i_shld = 0; tick(); tick();
    i_shld = 1; tick();
    for (int i = 0; i < 8; i++) begin
      oh[7 - i] = o_adrin1; ol[7 - i] = o_adrin2;
      i_serclk = 1; tick();
      i_serclk = 0; tick();
    end
    chk("ser_adrin1", oh, e[15:8]);
    chk("ser_adrin2", ol, e[7:0]);
    chk("ser_drained", {o_adrin1, o_adrin2}, 2'b00);
  endtask

  initial begin
    int acks, falls, rise1, fall2, cnt_ack, cnt_lo, g;
    logic pm;
    logic [15:0] e;
    // reset state
    repeat (3) tick();
    chk("reset_ctrl", {o_phi3, o_memen, o_dbin, o_we, o_a15, o_data_oe, o_busy, o_ack}, 8'b01010000);
    chk("reset_data", {o_data_bus, o_rdata}, 24'h0);
    chk("reset_ser", {o_adrin1, o_adrin2}, 2'b00);
    reset = 0; tick();
    chk("phi3_after_reset", o_phi3, 1);

    // read 0xA000, responder 0x12/0x34; then serialize that address
    do_txn(0, 16'hA000, 16'h0000, 16'h1234, 0, 0);
    ser_check(16'hA000);
    // write 0x2000 = 0xBEEF
    do_txn(1, 16'h2000, 16'hBEEF, 16'h0000, 0, 0);
    // ready low at 3 boundaries of the MSB byte
    do_txn(0, 16'h1234, 16'h0000, 16'hC3A5, 3, 0);
    do_txn(1, 16'h8ACE, 16'h5A69, 16'h0000, 2, 3);

    // load wins over a simultaneous shift clock
    do_txn(0, 16'h0040, 16'h0000, 16'h0F0F, 0, 0);
    e = scr(16'h0040, 1'b0);
    i_shld = 0; tick();
    i_serclk = 1; tick();
    chk("load_wins", o_adrin1, e[15]);
    i_shld = 1; i_serclk = 0; tick();
    i_serclk = 1; tick();
    chk("shift_after_load", o_adrin1, e[14]);
    i_serclk = 0; tick();

    // reset during the LSB byte of a write
    i_req = 1; i_write = 1; i_addr = 16'h4242; i_wdata = 16'h1357;
    tick();
    i_req = 0;
    g = 0;
    while (!o_a15 && g < 100) begin tick(); g++; end
    chk("reached_dlo", o_a15, 1);
    reset = 1; tick(); reset = 0;
    chk("midreset_bus", {o_memen, o_data_oe, o_we, o_a15, o_dbin, o_busy}, 6'b101000);
    chk("midreset_rdata", o_rdata, 0);
    exp_rdata = 0;
    cnt_ack = 0; cnt_lo = 0;
    repeat (60) begin
      if (o_ack) cnt_ack++;
      if (!o_memen) cnt_lo++;
      tick();
    end
    chk("midreset_no_ack", cnt_ack, 0);
    chk("midreset_no_cycle", cnt_lo, 0);
    do_txn(0, 16'h7FFE, 16'h0000, 16'hA55A, 0, 1);

    // request held through busy: two acceptances, one END period between them
    i_req = 1; i_write = 0; i_addr = 16'h3C3C; i_ready = 1; i_data_bus = 8'h5A;
    acks = 0; falls = 0; rise1 = -1; fall2 = -1; pm = o_memen;
    for (int c = 0; c < 140; c++) begin
      if (pm && !o_memen) begin falls++; if (falls == 2) fall2 = c; end
      if (!pm && o_memen && rise1 < 0) rise1 = c;
      pm = o_memen;
      if (o_ack) begin acks++; if (acks == 2) i_req = 0; end
      tick();
    end
    i_req = 0;
    chk("b2b_acks", acks, 2);
    chk("b2b_cycles", falls, 2);
    chk("b2b_gap", fall2 - rise1, P);
    chk("b2b_rdata", o_rdata, 16'h5A5A);
    exp_rdata = 16'h5A5A;

    // randomized transactions
    for (int n = 0; n < 20; n++) begin
      logic [15:0] a;
      a = 16'($urandom);
      repeat ($urandom_range(0, P + 1)) tick();
      do_txn(1'($urandom), a, 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3));
      if (n % 4 == 0) ser_check(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
